// File: rtl/ssp_serdes.sv
// TI synchronous-serial SSP serialiser/deserialiser: divided SSPCLKOUT, MSB-first transmit, synchronised receive.
// Latency: TX word starts one SSPCLKOUT period (frame pulse) after the pop; RX strobe 3 PCLK after LSB sample edge.
// Backpressure: none on the FIFO side; TxIsEmpty is only looked at on tick_rise, RxNextWord must be accepted.
module ssp_serdes #(
    parameter int DATA_WIDTH = 8,
    parameter int CLK_DIV    = 2
) (
    input  logic                  PCLK,
    input  logic                  CLEAR_B,
    input  logic                  LBM,
    input  logic [DATA_WIDTH-1:0] TxData,
    input  logic                  TxIsEmpty,
    output logic                  TxNextWord,
    output logic [DATA_WIDTH-1:0] RxData,
    output logic                  RxNextWord,
    input  logic                  SSPCLKIN,
    input  logic                  SSPFSSIN,
    input  logic                  SSPRXD,
    output logic                  SSPCLKOUT,
    output logic                  SSPFSSOUT,
    output logic                  SSPTXD,
    output logic                  SSPOE_B
);
    localparam int DIV_W = $clog2(CLK_DIV);
    localparam int CNT_W = $clog2(DATA_WIDTH);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

    logic [DIV_W-1:0] div_cnt;
    logic [DIV_W-1:0] div_nxt;
    logic             tick_rise;

    assign div_nxt   = (div_cnt == DIV_LAST) ? '0 : div_cnt + DIV_W'(1);
    assign tick_rise = (div_cnt == DIV_HALF - DIV_W'(1));

    always_ff @(posedge PCLK or negedge CLEAR_B) begin
        if (!CLEAR_B) begin
            div_cnt   <= '0;
            SSPCLKOUT <= 1'b0;
        end else begin
            div_cnt   <= div_nxt;
            SSPCLKOUT <= (div_nxt >= DIV_HALF);
        end
    end

    typedef enum logic [1:0] {TX_IDLE, TX_FRAME, TX_SHIFT} tx_state_t;

    tx_state_t             tx_state;
    logic [DATA_WIDTH-1:0] shift_out;
    logic [CNT_W-1:0]      bit_cnt;
    logic                  pend;
    logic                  tx_load;

    assign tx_load    = ((tx_state == TX_IDLE) && !TxIsEmpty) ||
                        ((tx_state == TX_SHIFT) && (bit_cnt == '0) && pend);
    // Gated by CLEAR_B so no pop can escape while the block is held in reset.
    assign TxNextWord = CLEAR_B && tick_rise && tx_load;
    assign SSPTXD     = !SSPOE_B && shift_out[DATA_WIDTH-1];

    always_ff @(posedge PCLK or negedge CLEAR_B) begin
        if (!CLEAR_B) begin
            tx_state  <= TX_IDLE;
            shift_out <= '0;
            bit_cnt   <= '0;
            pend      <= 1'b0;
            SSPFSSOUT <= 1'b0;
            SSPOE_B   <= 1'b1;
        end else if (tick_rise) begin
            case (tx_state)
                TX_IDLE: begin
                    if (!TxIsEmpty) begin
                        shift_out <= TxData;
                        SSPFSSOUT <= 1'b1;
                        tx_state  <= TX_FRAME;
                    end
                end
                TX_FRAME: begin
                    SSPFSSOUT <= 1'b0;
                    SSPOE_B   <= 1'b0;
                    bit_cnt   <= CNT_LAST;
                    tx_state  <= TX_SHIFT;
                end
                TX_SHIFT: begin
                    if (bit_cnt != '0) begin
                        shift_out <= {shift_out[DATA_WIDTH-2:0], 1'b0};
                        bit_cnt   <= bit_cnt - CNT_W'(1);
                        // Frame pulse for a follow-on word overlaps this word's LSB.
                        if (bit_cnt == CNT_W'(1)) begin
                            SSPFSSOUT <= !TxIsEmpty;
                            pend      <= !TxIsEmpty;
                        end
                    end else if (pend) begin
                        shift_out <= TxData;
                        SSPFSSOUT <= 1'b0;
                        pend      <= 1'b0;
                        bit_cnt   <= CNT_LAST;
                    end else begin
                        SSPOE_B  <= 1'b1;
                        tx_state <= TX_IDLE;
                    end
                end
                default: tx_state <= TX_IDLE;
            endcase
        end
    end

    logic       clk_src, fss_src, rxd_src;
    logic [1:0] clk_sync, fss_sync, rxd_sync;
    logic       clk_hist;
    logic       rx_sample;

    assign clk_src   = LBM ? SSPCLKOUT : SSPCLKIN;
    assign fss_src   = LBM ? SSPFSSOUT : SSPFSSIN;
    assign rxd_src   = LBM ? SSPTXD    : SSPRXD;
    assign rx_sample = clk_hist && !clk_sync[1];

    always_ff @(posedge PCLK or negedge CLEAR_B) begin
        if (!CLEAR_B) begin
            clk_sync <= '0;
            fss_sync <= '0;
            rxd_sync <= '0;
            clk_hist <= 1'b0;
        end else begin
            clk_sync <= {clk_sync[0], clk_src};
            fss_sync <= {fss_sync[0], fss_src};
            rxd_sync <= {rxd_sync[0], rxd_src};
            clk_hist <= clk_sync[1];
        end
    end

    typedef enum logic {RX_IDLE, RX_SHIFT} rx_state_t;

    rx_state_t             rx_state;
    logic [DATA_WIDTH-2:0] shift_in;
    logic [CNT_W-1:0]      rx_cnt;

    always_ff @(posedge PCLK or negedge CLEAR_B) begin
        if (!CLEAR_B) begin
            rx_state   <= RX_IDLE;
            shift_in   <= '0;
            rx_cnt     <= '0;
            RxData     <= '0;
            RxNextWord <= 1'b0;
        end else begin
            RxNextWord <= 1'b0;
            if (rx_sample) begin
                case (rx_state)
                    RX_IDLE: begin
                        if (fss_sync[1]) begin
                            rx_cnt   <= '0;
                            rx_state <= RX_SHIFT;
                        end
                    end
                    RX_SHIFT: begin
                        if (rx_cnt == CNT_LAST) begin
                            RxData     <= {shift_in, rxd_sync[1]};
                            RxNextWord <= 1'b1;
                            rx_cnt     <= '0;
                            if (!fss_sync[1]) rx_state <= RX_IDLE;
                        end else if (fss_sync[1]) begin
                            rx_cnt <= '0;
                        end else begin
                            shift_in <= {shift_in[DATA_WIDTH-3:0], rxd_sync[1]};
                            rx_cnt   <= rx_cnt + CNT_W'(1);
                        end
                    end
                    default: rx_state <= RX_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_ssp_serdes.sv
// Directed bench for ssp_serdes (DATA_WIDTH=8, CLK_DIV=4): FIFO model on the TX side, negedge monitor logging serial activity.
module tb_ssp_serdes;
    localparam int DW = 8;
    localparam int CD = 4;

    logic          PCLK = 1'b0;
    logic          CLEAR_B = 1'b1;
    logic          LBM = 1'b0;
    logic [DW-1:0] TxData = '0;
    logic          TxIsEmpty = 1'b1;
    logic          SSPCLKIN = 1'b0;
    logic          SSPFSSIN = 1'b0;
    logic          SSPRXD = 1'b0;
    logic          TxNextWord, RxNextWord;
    logic [DW-1:0] RxData;
    logic          SSPCLKOUT, SSPFSSOUT, SSPTXD, SSPOE_B;

    always #5 PCLK = ~PCLK;

    ssp_serdes #(.DATA_WIDTH(DW), .CLK_DIV(CD)) dut (
        .PCLK(PCLK), .CLEAR_B(CLEAR_B), .LBM(LBM),
        .TxData(TxData), .TxIsEmpty(TxIsEmpty), .TxNextWord(TxNextWord),
        .RxData(RxData), .RxNextWord(RxNextWord),
        .SSPCLKIN(SSPCLKIN), .SSPFSSIN(SSPFSSIN), .SSPRXD(SSPRXD),
        .SSPCLKOUT(SSPCLKOUT), .SSPFSSOUT(SSPFSSOUT), .SSPTXD(SSPTXD), .SSPOE_B(SSPOE_B)
    );

    int total = 0;
    int bad = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Monitor: everything is sampled on the falling PCLK edge.
    int            cyc = 0;
    logic          clk_prev = 1'b0;
    int            fss_len = 0, oe_len = 0;
    int            clk_rises = 0, txd_hi = 0;
    int            fss_runs[$], oe_runs[$], oe_starts[$], pop_cyc[$], rx_cyc[$];
    logic [DW-1:0] rx_words[$];
    bit            tx_bits[$];
    bit            pop_pending = 0;

    always @(negedge PCLK) begin
        cyc++;
        if (TxNextWord) begin
            pop_cyc.push_back(cyc);
            pop_pending = 1;
        end
        if (RxNextWord) begin
            rx_words.push_back(RxData);
            rx_cyc.push_back(cyc);
        end
        if (clk_prev && !SSPCLKOUT && !SSPOE_B) tx_bits.push_back(SSPTXD);
        if (!clk_prev && SSPCLKOUT) clk_rises++;
        if (SSPTXD) txd_hi++;
        if (SSPFSSOUT) fss_len++;
        else if (fss_len > 0) begin
            fss_runs.push_back(fss_len);
            fss_len = 0;
        end
        if (!SSPOE_B) begin
            if (oe_len == 0) oe_starts.push_back(cyc);
            oe_len++;
        end else if (oe_len > 0) begin
            oe_runs.push_back(oe_len);
            oe_len = 0;
        end
        clk_prev = SSPCLKOUT;
    end

    // Transmit FIFO model: head word on TxData, popped after each strobe.
    logic [DW-1:0] tx_fifo[$];

    always @(posedge PCLK) begin
        #1;
        if (pop_pending) begin
            if (tx_fifo.size() > 0) void'(tx_fifo.pop_front());
            pop_pending = 0;
        end
        TxIsEmpty = (tx_fifo.size() == 0);
        TxData    = (tx_fifo.size() > 0) ? tx_fifo[0] : '0;
    end

    task automatic clear_logs();
        fss_runs.delete(); oe_runs.delete(); oe_starts.delete();
        pop_cyc.delete(); rx_cyc.delete(); rx_words.delete(); tx_bits.delete();
    endtask

    function automatic int bits_value();
        int v = 0;
        foreach (tx_bits[i]) v = (v << 1) | int'(tx_bits[i]);
        return v;
    endfunction

    function automatic int q_at(input int q[$], input int idx);
        return (q.size() > idx) ? q[idx] : -1;
    endfunction

    task automatic wait_oe_done(input string name);
        for (int i = 0; i < 400 && oe_runs.size() == 0; i++) begin
            @(posedge PCLK); #1;
        end
        check(name, oe_runs.size(), 1);
        repeat (12) @(posedge PCLK);
        #1;
    endtask

    int fall_cyc = 0;

    task automatic ext_bit(input logic fss, input logic d);
        SSPCLKIN = 1'b1; SSPFSSIN = fss; SSPRXD = d;
        repeat (4) @(posedge PCLK);
        #1;
        SSPCLKIN = 1'b0;
        fall_cyc = cyc;
        repeat (4) @(posedge PCLK);
        #1;
    endtask

    typedef struct {
        logic [DW-1:0] data;
        logic          lbm;
        int            exp_bits;
        int            exp_rx_cnt;
        int            exp_rx;
    } tx_vec_t;

    tx_vec_t vecs[5];

    initial begin
        vecs[0] = '{8'hA5, 1'b0, 'b1010_0101, 0, 0};
        vecs[1] = '{8'h12, 1'b0, 'b0001_0010, 0, 0};
        vecs[2] = '{8'h81, 1'b1, 'b1000_0001, 1, 'h81};
        vecs[3] = '{8'h7E, 1'b1, 'b0111_1110, 1, 'h7E};
        vecs[4] = '{8'h00, 1'b1, 'b0000_0000, 1, 'h00};

        #2 CLEAR_B = 1'b0;
        repeat (3) @(posedge PCLK);
        #1;
        check("rst_oe_b", SSPOE_B, 1);
        check("rst_fss", SSPFSSOUT, 0);
        check("rst_txd", SSPTXD, 0);
        check("rst_clkout", SSPCLKOUT, 0);
        check("rst_txnext", TxNextWord, 0);
        check("rst_rxnext", RxNextWord, 0);
        check("rst_rxdata", RxData, 0);

        clear_logs();
        clk_rises = 0;
        txd_hi = 0;
        CLEAR_B = 1'b1;
        repeat (100) @(posedge PCLK);
        #1;
        check("idle_clk_rises", clk_rises, 100 / CD);
        check("idle_txd_high", txd_hi, 0);
        check("idle_fss_pulses", fss_runs.size() + fss_len, 0);
        check("idle_oe_low", oe_runs.size() + oe_len, 0);
        check("idle_pops", pop_cyc.size() + rx_words.size(), 0);

        for (int k = 0; k < 5; k++) begin
            LBM = vecs[k].lbm;
            repeat (4) @(posedge PCLK);
            #1;
            clear_logs();
            tx_fifo.push_back(vecs[k].data);
            wait_oe_done($sformatf("tx_done[%0d]", k));
            check($sformatf("tx_bits[%0d]", k), bits_value(), vecs[k].exp_bits);
            check($sformatf("tx_fss_len[%0d]", k), q_at(fss_runs, 0), CD);
            check($sformatf("tx_oe_len[%0d]", k), q_at(oe_runs, 0), DW * CD);
            check($sformatf("tx_pops[%0d]", k), pop_cyc.size(), 1);
            check($sformatf("rx_cnt[%0d]", k), rx_words.size(), vecs[k].exp_rx_cnt);
            if (vecs[k].exp_rx_cnt > 0 && rx_words.size() > 0)
                check($sformatf("rx_word[%0d]", k), rx_words[0], vecs[k].exp_rx);
        end

        // Back-to-back pair through loopback.
        LBM = 1'b1;
        repeat (4) @(posedge PCLK);
        #1;
        clear_logs();
        tx_fifo.push_back(8'h3C);
        tx_fifo.push_back(8'hFF);
        wait_oe_done("b2b_done");
        check("b2b_bits", bits_value(), 'h3CFF);
        check("b2b_oe_len", q_at(oe_runs, 0), 2 * DW * CD);
        check("b2b_fss_cnt", fss_runs.size(), 2);
        check("b2b_fss_lsb_len", q_at(fss_runs, 1), CD);
        check("b2b_pops", pop_cyc.size(), 2);
        // Strobes show in the PCLK before their tick edge; OE_B low shows the PCLK after the frame edge.
        check("b2b_pop_gap", q_at(pop_cyc, 1) - q_at(pop_cyc, 0), (DW + 1) * CD);
        check("b2b_oe_after_pop", q_at(oe_starts, 0) - q_at(pop_cyc, 0), CD + 1);
        check("b2b_rx_cnt", rx_words.size(), 2);
        if (rx_words.size() == 2) begin
            check("b2b_rx0", rx_words[0], 'h3C);
            check("b2b_rx1", rx_words[1], 'hFF);
        end

        // External receive, SSPCLKIN period 8 PCLK.
        LBM = 1'b0;
        repeat (4) @(posedge PCLK);
        #1;
        clear_logs();
        begin
            logic [DW-1:0] w;
            w = 8'h5A;
            ext_bit(1'b1, 1'b0);
            for (int i = DW - 1; i >= 0; i--) ext_bit(1'b0, w[i]);
        end
        SSPFSSIN = 1'b0; SSPRXD = 1'b0;
        repeat (8) @(posedge PCLK);
        #1;
        check("ext_rx_cnt", rx_words.size(), 1);
        check("ext_rx_word", rx_words.size() > 0 ? int'(rx_words[0]) : -1, 'h5A);
        check("ext_rx_timing", q_at(rx_cyc, 0) - fall_cyc, 4);

        clear_logs();
        begin
            logic [DW-1:0] w;
            w = 8'hC3;
            ext_bit(1'b1, 1'b0);
            for (int i = 0; i < 3; i++) ext_bit(1'b0, 1'b1);
            ext_bit(1'b1, 1'b0);
            for (int i = DW - 1; i >= 0; i--) ext_bit(1'b0, w[i]);
        end
        SSPFSSIN = 1'b0; SSPRXD = 1'b0;
        repeat (8) @(posedge PCLK);
        #1;
        check("resync_rx_cnt", rx_words.size(), 1);
        check("resync_rx_word", rx_words.size() > 0 ? int'(rx_words[0]) : -1, 'hC3);
        repeat (20) @(posedge PCLK);
        #1;
        check("rxdata_hold", RxData, 'hC3);

        // Reset in the middle of a loopback frame.
        LBM = 1'b1;
        repeat (4) @(posedge PCLK);
        #1;
        clear_logs();
        tx_fifo.push_back(8'hA5);
        for (int i = 0; i < 300 && tx_bits.size() < 3; i++) begin
            @(posedge PCLK); #1;
        end
        check("midrst_bits_seen", tx_bits.size(), 3);
        #1 CLEAR_B = 1'b0;
        #1;
        check("midrst_oe_b", SSPOE_B, 1);
        check("midrst_fss", SSPFSSOUT, 0);
        check("midrst_txd", SSPTXD, 0);
        check("midrst_clkout", SSPCLKOUT, 0);
        check("midrst_txnext", TxNextWord, 0);
        check("midrst_rxnext", RxNextWord, 0);
        check("midrst_rxdata", RxData, 0);
        repeat (10) @(posedge PCLK);
        #1;
        check("midrst_pops", pop_cyc.size(), 1);
        check("midrst_rx_cnt", rx_words.size(), 0);
        CLEAR_B = 1'b1;
        repeat (8) @(posedge PCLK);
        #1;
        check("postrst_rx_cnt", rx_words.size(), 0);
        clear_logs();
        tx_fifo.push_back(8'h12);
        wait_oe_done("postrst_done");
        check("postrst_bits", bits_value(), 'h12);
        check("postrst_fss_len", q_at(fss_runs, 0), CD);
        check("postrst_oe_len", q_at(oe_runs, 0), DW * CD);
        check("postrst_pops", pop_cyc.size(), 1);
        check("postrst_rx_cnt2", rx_words.size(), 1);
        check("postrst_rx_word", rx_words.size() > 0 ? int'(rx_words[0]) : -1, 'h12);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
